// File: rtl/stm_focus_sequencer.sv
// Point sequencer for the focus-STM datapath: divides UPDATE ticks into point steps,
// issues one START/IDX per point and tracks the datapath's DEPTH-beat busy window.
module stm_focus_sequencer #(
    parameter int DEPTH = 249,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             UPDATE,
    input  logic [WIDTH-1:0] CYCLE,
    input  logic [WIDTH-1:0] FREQ_DIV,
    input  logic [WIDTH-1:0] REP,
    input  logic             DOUT_VALID,
    output logic             START,
    output logic [WIDTH-1:0] IDX,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERRUN,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LAST_BEAT = WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] INF_REP   = '1;
    localparam logic [WIDTH-1:0] LOOP_SAT  = INF_REP - ONE;

    state_t           state;
    logic [WIDTH-1:0] cyc_last;
    logic [WIDTH-1:0] div_last;
    logic [WIDTH-1:0] rep_cfg;
    logic [WIDTH-1:0] nxt_idx;
    logic [WIDTH-1:0] div_cnt;
    logic [WIDTH-1:0] loop_cnt;
    logic [WIDTH-1:0] beat_cnt;
    logic             pend;

    logic issue;
    logic advance;
    logic wrap;
    logic last_loop;

    // Handshake: START is a one-cycle request with IDX held until the next START; the
    // datapath answers with exactly DEPTH DOUT_VALID beats, and no new START is raised
    // until the last of those beats has been seen (BUSY low).
    always_comb begin
        issue     = pend && !BUSY;
        advance   = UPDATE && (div_cnt == div_last);
        wrap      = (nxt_idx == cyc_last);
        last_loop = wrap && (rep_cfg != INF_REP) && (loop_cnt == rep_cfg);
    end

    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            START    <= 1'b0;
            IDX      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            OVERRUN  <= 1'b0;
            cyc_last <= '0;
            div_last <= '0;
            rep_cfg  <= '0;
            nxt_idx  <= '0;
            div_cnt  <= '0;
            loop_cnt <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
        end else begin
            START <= 1'b0;

            // Beat counting runs in every state so DRAIN and FIN see the datapath finish.
            if (BUSY && DOUT_VALID) begin
                beat_cnt <= beat_cnt + ONE;
                if (beat_cnt == LAST_BEAT) begin
                    BUSY <= 1'b0;
                end
            end

            unique case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (ENABLE) begin
                        cyc_last <= CYCLE;
                        div_last <= (FREQ_DIV == '0) ? '0 : FREQ_DIV - ONE;
                        rep_cfg  <= REP;
                        nxt_idx  <= '0;
                        div_cnt  <= '0;
                        loop_cnt <= '0;
                        pend     <= 1'b1;
                        OVERRUN  <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (!ENABLE) begin
                        pend  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        if (issue) begin
                            START    <= 1'b1;
                            IDX      <= nxt_idx;
                            BUSY     <= 1'b1;
                            beat_cnt <= '0;
                            pend     <= 1'b0;
                        end
                        if (UPDATE) begin
                            if (!advance) begin
                                div_cnt <= div_cnt + ONE;
                            end else begin
                                div_cnt <= '0;
                                nxt_idx <= wrap ? '0 : nxt_idx + ONE;
                                if (wrap && (loop_cnt != LOOP_SAT)) begin
                                    loop_cnt <= loop_cnt + ONE;
                                end
                                if (last_loop) begin
                                    pend  <= 1'b0;
                                    state <= FIN;
                                end else begin
                                    // A request still waiting (not consumed this cycle) is replaced.
                                    pend <= 1'b1;
                                    if (pend && !issue) begin
                                        OVERRUN <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (!BUSY) begin
                        state <= IDLE;
                    end
                end

                FIN: begin
                    if (!ENABLE) begin
                        DONE  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DONE <= !BUSY;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stm_focus_sequencer.sv
// Bench for stm_focus_sequencer: directed scenarios plus randomized configurations,
// scored against a point-level model built from tick counts and a DEPTH-beat datapath.
module tb_stm_focus_sequencer;

    localparam int DEPTH  = 249;
    localparam int WIDTH  = 16;
    localparam int DP_LAT = 85;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_FIN   = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ENABLE;
    logic             UPDATE;
    logic [WIDTH-1:0] CYCLE;
    logic [WIDTH-1:0] FREQ_DIV;
    logic [WIDTH-1:0] REP;
    logic             DOUT_VALID;
    logic             START;
    logic [WIDTH-1:0] IDX;
    logic             BUSY;
    logic             DONE;
    logic             OVERRUN;
    logic [1:0]       STATE;

    stm_focus_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .UPDATE     (UPDATE),
        .CYCLE      (CYCLE),
        .FREQ_DIV   (FREQ_DIV),
        .REP        (REP),
        .DOUT_VALID (DOUT_VALID),
        .START      (START),
        .IDX        (IDX),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN),
        .STATE      (STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_edge_q[$];

    int               edge_no = 0;
    int               m_state = M_IDLE;
    int               m_cycle, m_fdiv, m_rep;
    bit               m_inf;
    int               m_ticks, m_points;
    bit               m_busy = 0;
    int               m_beats = 0;
    bit               m_done = 0;
    bit               m_overrun = 0;
    logic [WIDTH-1:0] m_idx = '0;
    logic             prev_busy = 1'b0;
    logic             rst_prev = 1'b0;
    int               n_elig;
    int               n_starts = 0;
    logic [WIDTH-1:0] last_pt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push_point(input int pt);
        exp_q.push_back(WIDTH'(pt));
        exp_edge_q.push_back(edge_no + 1);
    endtask

    // ---------------- monitor: compare, then advance model with inputs sampled next edge ----------------
    always @(negedge CLK) begin
        edge_no++;

        if (START === 1'b1) begin
            n_starts++;
            n_elig = 0;
            while (exp_q.size() > 0 && exp_edge_q[0] < edge_no) begin
                last_pt = exp_q.pop_front();
                void'(exp_edge_q.pop_front());
                n_elig++;
            end
            check("start_expected", (n_elig > 0) ? 32'd1 : 32'd0, 32'd1);
            if (n_elig > 0) begin
                if (n_elig > 1) m_overrun = 1;
                m_idx = last_pt;
            end
            check("start_while_busy", 32'(prev_busy), 32'd0);
            m_busy  = 1;
            m_beats = 0;
        end

        check("idx", 32'(IDX), 32'(m_idx));
        check("busy", 32'(BUSY), 32'(m_busy));
        check("done", 32'(DONE), 32'(m_done));
        if (rst_prev) begin
            check("rst_overrun", 32'(OVERRUN), 32'd0);
            check("rst_start", 32'(START), 32'd0);
        end

        if (m_state == M_FIN && exp_q.size() > 0) begin
            if (exp_q.size() > 1) m_overrun = 1;
            exp_q.delete();
            exp_edge_q.delete();
        end
        prev_busy = BUSY;

        rst_prev = RST;
        if (RST) begin
            m_state   = M_IDLE;
            m_busy    = 0;
            m_done    = 0;
            m_overrun = 0;
            m_idx     = '0;
            exp_q.delete();
            exp_edge_q.delete();
        end else begin
            case (m_state)
                M_IDLE: if (ENABLE) begin
                    m_cycle   = int'(CYCLE);
                    m_fdiv    = (FREQ_DIV == 0) ? 1 : int'(FREQ_DIV);
                    m_rep     = int'(REP);
                    m_inf     = (REP == 16'hFFFF);
                    m_ticks   = 0;
                    m_points  = 0;
                    m_overrun = 0;
                    m_state   = M_RUN;
                    push_point(0);
                end
                M_RUN: begin
                    if (!ENABLE) begin
                        if (exp_q.size() > 1) m_overrun = 1;
                        exp_q.delete();
                        exp_edge_q.delete();
                        m_state = M_DRAIN;
                    end else if (UPDATE) begin
                        m_ticks++;
                        if (m_ticks % m_fdiv == 0) begin
                            m_points++;
                            if (!m_inf && m_points == (m_rep + 1) * (m_cycle + 1))
                                m_state = M_FIN;
                            else
                                push_point(m_points % (m_cycle + 1));
                        end
                    end
                end
                M_DRAIN: if (!m_busy) m_state = M_IDLE;
                M_FIN: begin
                    if (!ENABLE) begin
                        m_done  = 0;
                        m_state = M_IDLE;
                    end else begin
                        m_done = !m_busy;
                    end
                end
                default: m_state = M_IDLE;
            endcase
            if (m_busy && DOUT_VALID) begin
                m_beats++;
                if (m_beats == DEPTH) m_busy = 0;
            end
        end
    end

    // ---------------- datapath model: DEPTH beats, DP_LAT cycles after START ----------------
    initial begin
        DOUT_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (START === 1'b1) begin
                repeat (DP_LAT) @(posedge CLK);
                #1 DOUT_VALID = 1'b1;
                repeat (DEPTH) @(posedge CLK);
                #1 DOUT_VALID = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_update(input int gap);
        step(gap - 1);
        UPDATE = 1'b1;
        step(1);
        UPDATE = 1'b0;
    endtask

    task automatic configure(input int cyc, input int fdiv, input int rep);
        CYCLE    = WIDTH'(cyc);
        FREQ_DIV = WIDTH'(fdiv);
        REP      = WIDTH'(rep);
    endtask

    task automatic wait_start(input string name, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (START === 1'b1) found = 1;
        end
        check(name, 32'(found), 32'd1);
        step(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) found = 1;
        end
        check(name, 32'(found), 32'd1);
        step(1);
    endtask

    // ---------------- stimulus ----------------
    int s0;
    int r_cyc, r_div, r_rep, r_gap;

    initial begin
        RST = 1'b1; ENABLE = 1'b0; UPDATE = 1'b0;
        configure(0, 0, 0);
        step(3);
        check("reset_idx", 32'(IDX), 32'd0);
        check("reset_overrun", 32'(OVERRUN), 32'd0);
        check("reset_state", 32'(STATE), 32'd0);
        RST = 1'b0;
        step(2);

        // Looping four-point sequence, two ticks per point.
        configure(3, 2, 16'hFFFF);
        ENABLE = 1'b1;
        for (int i = 0; i < 12; i++) pulse_update(1000);
        step(500);
        check("t1_overrun_model", 32'(OVERRUN), 32'(m_overrun));
        check("t1_overrun", 32'(OVERRUN), 32'd0);
        ENABLE = 1'b0;
        step(400);

        // Finite run: two points, one repeat, then FIN.
        s0 = n_starts;
        configure(1, 1, 1);
        ENABLE = 1'b1;
        for (int i = 0; i < 6; i++) pulse_update(400);
        wait_done("t2_wait_done", 1000);
        check("t2_starts", 32'(n_starts - s0), 32'd4);
        check("t2_state_fin", 32'(STATE), 32'd3);
        ENABLE = 1'b0;
        step(20);
        check("t2_done_clear", 32'(DONE), 32'd0);
        step(20);

        // Ticks faster than the datapath drains.
        configure(7, 1, 16'hFFFF);
        ENABLE = 1'b1;
        for (int i = 0; i < 12; i++) pulse_update(100);
        step(500);
        check("t3_overrun_model", 32'(OVERRUN), 32'(m_overrun));
        check("t3_overrun", 32'(OVERRUN), 32'd1);
        ENABLE = 1'b0;
        step(400);

        // Disable mid-computation, with a brief re-enable while draining.
        configure(3, 1, 16'hFFFF);
        ENABLE = 1'b1;
        wait_start("t4_wait_start", 20);
        step(9);
        ENABLE = 1'b0;
        step(30);
        check("t4_state_drain", 32'(STATE), 32'd2);
        ENABLE = 1'b1;
        step(3);
        ENABLE = 1'b0;
        step(30);
        ENABLE = 1'b1;
        step(400);
        ENABLE = 1'b0;
        step(400);
        check("t4_busy_idle", 32'(BUSY), 32'd0);
        check("t4_state_idle", 32'(STATE), 32'd0);

        // Reset in the middle of the datapath burst.
        configure(2, 1, 16'hFFFF);
        ENABLE = 1'b1;
        wait_start("t5_wait_start", 20);
        step(DP_LAT + 230);
        RST = 1'b1; ENABLE = 1'b0;
        step(5);
        RST = 1'b0;
        step(20);
        ENABLE = 1'b1;
        step(400);
        check("t5_overrun", 32'(OVERRUN), 32'd0);
        ENABLE = 1'b0;
        step(400);

        // FREQ_DIV=0 with a single point.
        configure(0, 0, 16'hFFFF);
        ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) pulse_update(400);
        for (int i = 0; i < 3; i++) pulse_update(150);
        step(500);
        check("t6_overrun_model", 32'(OVERRUN), 32'(m_overrun));
        ENABLE = 1'b0;
        step(400);

        // Randomized configurations and tick spacing.
        for (int r = 0; r < 4; r++) begin
            r_cyc = $urandom_range(0, 4);
            r_div = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: r_rep = 0;
                1: r_rep = 1;
                2: r_rep = 2;
                default: r_rep = 16'hFFFF;
            endcase
            configure(r_cyc, r_div, r_rep);
            ENABLE = 1'b1;
            for (int i = 0; i < 10; i++) begin
                r_gap = $urandom_range(60, 500);
                pulse_update(r_gap);
            end
            step(500);
            check("rnd_overrun_model", 32'(OVERRUN), 32'(m_overrun));
            ENABLE = 1'b0;
            step(400);
        end

        check("final_busy", 32'(BUSY), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
